// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one level-started UART transmitter between
// NUM_REQ byte producers, with frame counting and a hung-transmitter timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int GAP_CYCLES     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic [4:0]             tx_state,
    output logic                   active,
    output logic [2:0]             active_id,
    output logic [15:0]            byte_count,
    output logic                   timeout_err
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [4:0]       TX_DONE  = 5'h10;
    localparam logic [4:0]       TX_IDLE  = 5'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_r;
    logic [2:0]         last_grant_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;

    logic [7:0]         req_ext_s;
    logic [3:0]         cand_s;
    logic               hit_s;
    logic               found_s;
    logic [2:0]         grant_idx_s;
    logic [7:0]         grant_data_s;
    logic [NUM_REQ-1:0] ack_onehot_s;

    // Round-robin scan starting just after the last granted requester
    always_comb begin
        req_ext_s   = 8'(req);
        found_s     = 1'b0;
        grant_idx_s = 3'd0;
        cand_s      = 4'd0;
        hit_s       = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s      = {1'b0, last_grant_r} + 4'(k);
            cand_s      = (cand_s >= 4'(NUM_REQ)) ? (cand_s - 4'(NUM_REQ)) : cand_s;
            hit_s       = req_ext_s[cand_s[2:0]];
            grant_idx_s = (hit_s && !found_s) ? cand_s[2:0] : grant_idx_s;
            found_s     = found_s | hit_s;
        end
        grant_data_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_data_s = (grant_idx_s == 3'(i)) ? req_data[8*i +: 8] : grant_data_s;
        end
        ack_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end

    // Arbitration FSM; every output is a register so tx_start and req_ack are glitch-free
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= 3'(NUM_REQ - 1);
            to_cnt_r     <= {TO_W{1'b0}};
            gap_cnt_r    <= {GAP_W{1'b0}};
            req_ack      <= {NUM_REQ{1'b0}};
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            active       <= 1'b0;
            active_id    <= 3'd0;
            byte_count   <= 16'h0000;
            timeout_err  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        req_ack      <= ack_onehot_s;
                        tx_data      <= grant_data_s;
                        active_id    <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        tx_start     <= 1'b1;
                        active       <= 1'b1;
                        to_cnt_r     <= {TO_W{1'b0}};
                        state_r      <= SEND;
                    end else begin
                        req_ack  <= {NUM_REQ{1'b0}};
                        tx_start <= 1'b0;
                        active   <= 1'b0;
                    end
                end
                SEND: begin
                    req_ack  <= {NUM_REQ{1'b0}};
                    to_cnt_r <= to_cnt_r + 1'b1;
                    if (tx_state == TX_DONE) begin
                        byte_count <= byte_count + 16'd1;
                        tx_start   <= 1'b0;
                        gap_cnt_r  <= {GAP_W{1'b0}};
                        state_r    <= GAP;
                    end else if (to_cnt_r == TO_LAST) begin
                        // The byte is abandoned; dropping start aborts the transmitter
                        timeout_err <= 1'b1;
                        tx_start    <= 1'b0;
                        gap_cnt_r   <= {GAP_W{1'b0}};
                        state_r     <= GAP;
                    end else begin
                        tx_start <= 1'b1;
                    end
                end
                GAP: begin
                    req_ack  <= {NUM_REQ{1'b0}};
                    tx_start <= 1'b0;
                    if ((gap_cnt_r == GAP_LAST) && (tx_state == TX_IDLE)) begin
                        active  <= 1'b0;
                        state_r <= IDLE;
                    end else if (gap_cnt_r != GAP_LAST) begin
                        gap_cnt_r <= gap_cnt_r + 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r;
                    end
                end
                default: begin
                    req_ack  <= {NUM_REQ{1'b0}};
                    tx_start <= 1'b0;
                    active   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter with a behavioural transmitter
// model and a round-robin reference model in the monitor.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 2048;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [8*N-1:0]  req_data = '0;
    logic [N-1:0]    req_ack;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic [4:0]      xs = 5'h00;
    logic            active;
    logic [2:0]      active_id;
    logic [15:0]     byte_count;
    logic            timeout_err;

    logic [7:0]      cap = 8'h00;
    int              xcnt = 0;
    logic            hung = 1'b0;
    logic            long_frames = 1'b0;
    logic            wrap_load = 1'b0;
    logic            done = 1'b0;
    int              stall_events = 0;

    int              checks = 0;
    int              failures = 0;
    logic [7:0]      rq [N][$];
    logic [7:0]      sb [$];

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_ack(req_ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_state(xs), .active(active),
        .active_id(active_id), .byte_count(byte_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Transmitter stand-in: starts on tx_start, reports 5'h10 at frame end, clears after start drops
    always @(posedge clk) begin
        if (xs == 5'h00) begin
            if (tx_start) begin
                cap  <= tx_data;
                xs   <= 5'h01;
                xcnt <= long_frames ? 40 : int'($urandom_range(20, 3));
            end
        end else if (!tx_start) begin
            xs <= 5'h00;
        end else if (xs == 5'h01 && !hung) begin
            if (xcnt <= 1) xs <= 5'h10;
            else xcnt <= xcnt - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += rq[i].size();
        return s;
    endfunction

    // Requesters: pop on ack, present the queue head (random junk data when idle)
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req[i] = 1'b1;
                req_data[8*i +: 8] = rq[i][0];
            end else begin
                req[i] = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 3) begin
            tick();
            n++;
            if (pending() == 0 && req == '0 && !active && xs == 5'h00) quiet++;
            else quiet = 0;
            if (n > budget) begin
                stall_events++;
                break;
            end
        end
    endtask

    // Monitor and reference model
    initial begin
        logic [N-1:0]   p_req = '0;
        logic [N-1:0]   p_ack = '0;
        logic [8*N-1:0] p_data = '0;
        logic           p_reset = 1'b0;
        logic           p_start = 1'b0;
        logic           p_wrap = 1'b0;
        logic [4:0]     p_state = 5'h00;
        int             m_last = N - 1;
        int             m_id = 0;
        logic [15:0]    m_count = 16'h0000;
        logic           m_err = 1'b0;
        logic           frame_done = 1'b0;
        int             send_len = 0;
        int             exp_id;
        forever begin
            @(negedge clk);
            if (p_reset) begin
                chk("rst_tx_start", tx_start, 0);
                chk("rst_req_ack", req_ack, 0);
                chk("rst_byte_count", byte_count, 0);
                chk("rst_timeout_err", timeout_err, 0);
                chk("rst_active", active, 0);
                chk("rst_active_id", active_id, 0);
                chk("rst_tx_data", tx_data, 0);
                m_last = N - 1; m_id = 0; m_count = 16'h0000; m_err = 1'b0;
                sb.delete(); frame_done = 1'b0; send_len = 0;
            end else begin
                if (wrap_load != p_wrap) m_count = 16'hFFFF;
                if (req_ack != '0) begin
                    exp_id = rr_pick(p_req, m_last);
                    chk("ack_single_cycle", p_ack, 0);
                    chk("ack_onehot", $countones(req_ack), 1);
                    if (exp_id < 0) begin
                        chk("ack_without_req", req_ack, 0);
                    end else begin
                        chk("ack_winner", req_ack, 1 << exp_id);
                        m_last = exp_id;
                        m_id = exp_id;
                        sb.push_back(p_data[8*exp_id +: 8]);
                    end
                    frame_done = 1'b0;
                    send_len = 0;
                end
                chk("active_id", active_id, m_id);
                if (tx_start) begin
                    send_len++;
                    chk("active_in_send", active, 1);
                    if (sb.size() == 0) chk("start_without_grant", tx_start, 0);
                    else chk("tx_data_stable", tx_data, sb[0]);
                end
                if (xs == 5'h10 && p_state != 5'h10) begin
                    chk("start_held_to_done", tx_start, 1);
                    if (sb.size() == 0) begin
                        chk("frame_without_grant", sb.size(), 1);
                    end else begin
                        chk("frame_byte", cap, sb.pop_front());
                        frame_done = 1'b1;
                    end
                end
                if (p_start && !tx_start) begin
                    if (frame_done) begin
                        m_count++;
                    end else begin
                        m_err = 1'b1;
                        chk("timeout_send_len", send_len, TO);
                        if (sb.size() > 0) void'(sb.pop_front());
                    end
                    frame_done = 1'b0;
                    chk("byte_count", byte_count, m_count);
                    chk("timeout_err", timeout_err, m_err);
                end
            end
            p_req = req; p_ack = req_ack; p_data = req_data; p_reset = reset;
            p_start = tx_start; p_wrap = wrap_load; p_state = xs;
            if (done) begin
                chk("no_stalls", stall_events, 0);
                chk("scoreboard_empty", sb.size(), 0);
                chk("final_byte_count", byte_count, m_count);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    // Stimulus sequence
    initial begin
        int n;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        rq[0].push_back(8'hA5);
        drain(2000);

        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) rq[i].push_back(8'(16 + i));
        drain(4000);

        // Leave last grant at 2, then offer 0 and 2 together
        rq[2].push_back(8'h22);
        drain(2000);
        rq[0].push_back(8'h01);
        rq[2].push_back(8'h02);
        drain(2000);

        repeat (1500) begin
            if ($urandom_range(3, 0) == 0) begin
                int i;
                i = int'($urandom_range(N - 1, 0));
                if (rq[i].size() < 4) rq[i].push_back(8'($urandom));
            end
            tick();
        end
        drain(4000);

        // Hung transmitter
        hung = 1'b1;
        rq[1].push_back(8'h5A);
        n = 0;
        while (!timeout_err && n < 3000) begin
            tick();
            n++;
        end
        if (!timeout_err) stall_events++;
        hung = 1'b0;
        drain(3000);
        rq[3].push_back(8'hC3);
        drain(2000);

        // Reset in the middle of a long frame
        long_frames = 1'b1;
        rq[0].push_back(8'h3C);
        rq[1].push_back(8'h4D);
        n = 0;
        begin
            int mid = 0;
            while (mid < 15 && n < 500) begin
                tick();
                n++;
                if (xs == 5'h01) mid++;
            end
            if (mid < 15) stall_events++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        long_frames = 1'b0;
        drain(2000);
        rq[2].push_back(8'h96);
        drain(2000);

        // Counter wrap
        force dut.byte_count = 16'hFFFF;
        wrap_load = ~wrap_load;
        tick();
        release dut.byte_count;
        tick();
        rq[2].push_back(8'h77);
        drain(2000);

        done = 1'b1;
        repeat (5) tick();
    end

endmodule
